// File: rtl/bicubic_pkg.sv
// Shared types and the per-channel round/shift/clamp helper for the
// bicubic result packer. Optional feature macro: BICUBIC_RESULT_ROUND_EN
// (defined: round half up before the shift; undefined: truncate toward -inf).
package bicubic_pkg;

  localparam int FRAC_BITS  = 14;
  // Arithmetic width for the helper; wide enough for any product width up
  // to 62 bits plus the sign extension and rounding carry.
  localparam int CALC_WIDTH = 64;

  typedef logic [7:0] pixel_t;

  typedef struct packed {
    pixel_t r;
    pixel_t g;
    pixel_t b;
  } rgb_t;

  typedef struct packed {
    logic sof;
    logic eol;
    rgb_t rgb;
  } pix_word_t;

  // Add the rounding term, arithmetic-shift out the fraction, clamp to 0..255.
  function automatic pixel_t round_clamp(input logic signed [CALC_WIDTH-1:0] prod,
                                         input int frac_bits);
    logic signed [CALC_WIDTH-1:0] round_term;
    logic signed [CALC_WIDTH-1:0] shifted;
`ifdef BICUBIC_RESULT_ROUND_EN
    round_term = 64'sd1 <<< (frac_bits - 1);
`else
    round_term = 64'sd0;
`endif
    shifted = (prod + round_term) >>> frac_bits;
    if (shifted < 64'sd0) begin
      round_clamp = 8'h00;
    end else if (shifted > 64'sd255) begin
      round_clamp = 8'hFF;
    end else begin
      round_clamp = shifted[7:0];
    end
  endfunction

endpackage

// File: rtl/bicubic_sync_fifo.sv
// Single-clock FIFO with registered storage, push/pop/count. DEPTH must be a
// power of two so the pointers wrap naturally.
module bicubic_sync_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify push/pop so a pop on empty or a push on full is ignored.
  always_comb begin
    do_pop_s  = pop & (count_r != {CNT_W{1'b0}});
    do_push_s = push & ((count_r != CNT_W'(DEPTH)) | do_pop_s);
    rdata     = mem_r[rd_ptr_r];
    count     = count_r;
    empty     = (count_r == {CNT_W{1'b0}});
  end

  // Storage, pointers and occupancy; simultaneous push and pop keeps count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/bicubic_result_packer.sv
// Rounds/clamps three signed channel inner products into a 24-bit RGB pixel,
// tags it with start-of-frame / end-of-line and buffers it behind a
// valid/ready handshake. Optional feature macro: BICUBIC_RESULT_ROUND_EN.
module bicubic_result_packer
  import bicubic_pkg::*;
#(
  parameter int PRODUCT_WIDTH = 32,
  parameter int FRAC_BITS     = bicubic_pkg::FRAC_BITS,
  parameter int OUT_WIDTH     = 3840,
  parameter int OUT_HEIGHT    = 2160,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [PRODUCT_WIDTH-1:0] s_prod_r,
  input  logic [PRODUCT_WIDTH-1:0] s_prod_g,
  input  logic [PRODUCT_WIDTH-1:0] s_prod_b,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [23:0]              m_data,
  output logic                     m_sof,
  output logic                     m_eol
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int COL_W  = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam int ROW_W  = (OUT_HEIGHT > 1) ? $clog2(OUT_HEIGHT) : 1;
  localparam int EXT_W  = CALC_WIDTH - PRODUCT_WIDTH;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_HEIGHT - 1);

  logic             ready_en_r;
  logic             pipe_valid_r;
  rgb_t             pipe_rgb_r;
  logic [COL_W-1:0] wr_col_r;
  logic [ROW_W-1:0] wr_row_r;

  logic             accept_s;
  logic             pop_s;
  logic [CNT_W-1:0] occupancy_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic             fifo_empty_s;
  pix_word_t        fifo_head_s;
  pix_word_t        wr_word_s;
  rgb_t             rgb_next_s;

  // Handshakes, per-channel conversion and output decode of the FIFO head.
  always_comb begin
    occupancy_s  = {{(CNT_W-1){1'b0}}, pipe_valid_r} + fifo_count_s;
    s_ready      = ready_en_r & (occupancy_s < CNT_W'(FIFO_DEPTH));
    accept_s     = s_valid & s_ready;
    pop_s        = (~fifo_empty_s) & m_ready;
    rgb_next_s.r = round_clamp({{EXT_W{s_prod_r[PRODUCT_WIDTH-1]}}, s_prod_r}, FRAC_BITS);
    rgb_next_s.g = round_clamp({{EXT_W{s_prod_g[PRODUCT_WIDTH-1]}}, s_prod_g}, FRAC_BITS);
    rgb_next_s.b = round_clamp({{EXT_W{s_prod_b[PRODUCT_WIDTH-1]}}, s_prod_b}, FRAC_BITS);
    wr_word_s.sof = (wr_row_r == {ROW_W{1'b0}}) && (wr_col_r == {COL_W{1'b0}});
    wr_word_s.eol = (wr_col_r == COL_LAST);
    wr_word_s.rgb = pipe_rgb_r;
    m_valid      = ~fifo_empty_s;
    m_data       = fifo_head_s.rgb;
    m_sof        = fifo_head_s.sof;
    m_eol        = fifo_head_s.eol;
  end

  // Keep s_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // Stage P: capture the converted pixel of an accepted triple.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid_r <= 1'b0;
      pipe_rgb_r   <= 24'h000000;
    end else if (accept_s) begin
      pipe_valid_r <= 1'b1;
      pipe_rgb_r   <= rgb_next_s;
    end else begin
      pipe_valid_r <= 1'b0;
    end
  end

  // Write-side position counters; FIFO order equals output order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_col_r <= {COL_W{1'b0}};
      wr_row_r <= {ROW_W{1'b0}};
    end else if (pipe_valid_r) begin
      if (wr_col_r == COL_LAST) begin
        wr_col_r <= {COL_W{1'b0}};
        wr_row_r <= (wr_row_r == ROW_LAST) ? {ROW_W{1'b0}} : wr_row_r + ROW_W'(1);
      end else begin
        wr_col_r <= wr_col_r + COL_W'(1);
      end
    end
  end

  bicubic_sync_fifo #(
    .WIDTH ($bits(pix_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pipe_valid_r),
    .pop   (pop_s),
    .wdata (wr_word_s),
    .rdata (fifo_head_s),
    .count (fifo_count_s),
    .empty (fifo_empty_s)
  );

endmodule

// File: tb/tb_bicubic_result_packer.sv
// Bench for bicubic_result_packer: vector table, backpressure, framing,
// mid-frame reset and a random valid/ready stream against a scoreboard.
module tb_bicubic_result_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_prod_r = 32'd0;
  logic [31:0] s_prod_g = 32'd0;
  logic [31:0] s_prod_b = 32'd0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [23:0] m_data;
  logic        m_sof;
  logic        m_eol;

  int checks = 0;
  int failures = 0;
  int idx = 0;
  int accepted = 0;
  logic [25:0] sb[$];

  typedef struct {
    logic [31:0] r;
    logic [31:0] g;
    logic [31:0] b;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  bicubic_result_packer #(
    .PRODUCT_WIDTH (32),
    .FRAC_BITS     (14),
    .OUT_WIDTH     (4),
    .OUT_HEIGHT    (2),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_prod_r (s_prod_r),
    .s_prod_g (s_prod_g),
    .s_prod_b (s_prod_b),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_sof    (m_sof),
    .m_eol    (m_eol)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: floor division by 2^14 (after optional half-up term), then clamp.
  function automatic logic [7:0] model(input logic [31:0] p);
    longint v;
    longint q;
    v = longint'($signed(p));
`ifdef BICUBIC_RESULT_ROUND_EN
    v = v + 64'sd8192;
`endif
    q = v / 64'sd16384;
    if ((v < 0) && (q * 64'sd16384 != v)) q = q - 64'sd1;
    if (q < 0) return 8'h00;
    if (q > 255) return 8'hFF;
    return q[7:0];
  endfunction

  function automatic logic [31:0] rnd_prod();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return ($urandom_range(0, 255) << 14) + $urandom_range(0, 16383);
      2: return 32'd0 - $urandom_range(0, 100000);
      default: return ($urandom_range(250, 270) << 14) + $urandom_range(0, 16383);
    endcase
  endfunction

  // One cycle: drive at the falling edge, then score the transfers that the
  // next rising edge will perform.
  task automatic step(input bit sv, input logic [31:0] r, input logic [31:0] g,
                      input logic [31:0] b, input bit mr, input logic [23:0] exp_data);
    logic [25:0] e;
    @(negedge clk);
    s_valid = sv;
    s_prod_r = r;
    s_prod_g = g;
    s_prod_b = b;
    m_ready = mr;
    if (m_valid && m_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_pixel", {6'd0, m_sof, m_eol, m_data}, 32'hFFFFFFFF);
      end else begin
        e = sb.pop_front();
        chk("pixel", {6'd0, m_sof, m_eol, m_data}, {6'd0, e});
      end
    end
    if (s_valid && s_ready) begin
      sb.push_back({(idx % 8) == 0, (idx % 4) == 3, exp_data});
      idx++;
      accepted++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {8'd0, m_data}, 32'd0);
    chk("rst_tags", {30'd0, m_sof, m_eol}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    sb.delete();
    idx = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("s_ready_before_edge", {31'd0, s_ready}, 32'd0);
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 24'd0);
    chk("s_ready_after_release", {31'd0, s_ready}, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 24'd0);
    end
    chk("drain_empty", sb.size(), 32'd0);
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 24'd0);
    chk("no_extra_output", {31'd0, m_valid}, 32'd0);
  endtask

  initial begin
    int a0;
    int sent;
    logic [31:0] r;
    logic [31:0] g;
    logic [31:0] b;
    bit sv;

    vecs[0] = '{32'd100 << 14, 32'hFFFFFFFB, 32'd300 << 14, 24'h6400FF};
`ifdef BICUBIC_RESULT_ROUND_EN
    vecs[1] = '{(32'd7 << 14) + 32'd8192, 32'd0, 32'd0, 24'h080000};
    vecs[5] = '{32'hFFFFE000, 32'd8192, 32'd42 << 14, 24'h00012A};
`else
    vecs[1] = '{(32'd7 << 14) + 32'd8192, 32'd0, 32'd0, 24'h070000};
    vecs[5] = '{32'hFFFFE000, 32'd8192, 32'd42 << 14, 24'h00002A};
`endif
    vecs[2] = '{(32'd7 << 14) + 32'd8191, 32'd0, 32'd0, 24'h070000};
    vecs[3] = '{(32'd255 << 14) + 32'd16383, 32'd256 << 14, 32'hFFFFFFFF, 24'hFFFF00};
    vecs[4] = '{32'h7FFFFFFF, 32'd128 << 14, 32'h80000000, 24'hFF8000};

    // Reset values and latency of the first pixel.
    do_reset();
    step(1'b1, vecs[0].r, vecs[0].g, vecs[0].b, 1'b1, vecs[0].exp);
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 24'd0);
    chk("latency_not_yet", {31'd0, m_valid}, 32'd0);
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 24'd0);
    chk("latency_valid", {31'd0, m_valid}, 32'd1);
    chk("latency_data", {8'd0, m_data}, 32'h006400FF);
    drain();

    // Table vectors streamed back to back; also covers framing of 9 pixels.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, vecs[i % 6].r, vecs[i % 6].g, vecs[i % 6].b, 1'b1, vecs[i % 6].exp);
    end
    chk("stream_accepts", idx, 32'd9);
    drain();

    // Backpressure: only FIFO_DEPTH triples fit with m_ready low.
    do_reset();
    a0 = accepted;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 32'(i + 1) << 14, 32'(i + 10) << 14, 32'(i + 20) << 14, 1'b0,
           {8'(i + 1), 8'(i + 10), 8'(i + 20)});
    end
    chk("bp_accepts", accepted - a0, 32'd4);
    chk("bp_ready_low", {31'd0, s_ready}, 32'd0);
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 24'd0);
    chk("bp_ready_before_pop", {31'd0, s_ready}, 32'd0);
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 24'd0);
    chk("bp_ready_after_pop", {31'd0, s_ready}, 32'd1);
    drain();

    // Mid-frame reset: 5 pixels out, 2 still buffered.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'(i + 50) << 14, 32'd0, 32'd0, 1'b1, {8'(i + 50), 16'd0});
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 24'd0);
    end
    chk("mid_popped_all5", sb.size(), 32'd0);
    step(1'b1, 32'd60 << 14, 32'd0, 32'd0, 1'b0, 24'h3C0000);
    step(1'b1, 32'd61 << 14, 32'd0, 32'd0, 1'b0, 24'h3D0000);
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 24'd0);
    step(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 24'd0);
    chk("mid_held_valid", {31'd0, m_valid}, 32'd1);
    do_reset();
    step(1'b1, 32'd77 << 14, 32'd33 << 14, 32'd11 << 14, 1'b1, 24'h4D210B);
    drain();

    // Random valid/ready stream of 10k triples.
    sent = 0;
    for (int cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
      a0 = accepted;
      sv = ($urandom_range(0, 2) != 0);
      r = rnd_prod();
      g = rnd_prod();
      b = rnd_prod();
      step(sv, r, g, b, $urandom_range(0, 3) != 0, {model(r), model(g), model(b)});
      sent = sent + (accepted - a0);
    end
    chk("random_sent", sent, 32'd10000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
